// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional macro ALU_ARB_DIVZ_ERR_EN adds a registered divide-by-zero flag on resp_err.
module alu_req_arbiter #(
    parameter int EXEC_CYCLES = 1  // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [7:0] resp_data,
    output logic       resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       grant_id;
    logic       sel_id;
    logic       accept;
    logic [3:0] cnt;

    // Valid/ready: a command transfers on a rising edge where valid and ready are both high;
    // ready is combinational, only in IDLE, and only for the single selected requester.
    always_comb begin
        sel_id = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_id = ~last_grant;
        end else if (req1_valid) begin
            sel_id = 1'b1;
        end
    end

    assign accept     = !rst && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !sel_id;
    assign req1_ready = accept && sel_id;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            cnt        <= 4'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_op     <= 3'd0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // The ALU lines double as the latched command; they stay put until IDLE.
                    if (accept) begin
                        grant_id   <= sel_id;
                        last_grant <= sel_id;
                        cnt        <= EXEC_LOAD;
                        alu_a      <= sel_id ? req1_a  : req0_a;
                        alu_b      <= sel_id ? req1_b  : req0_b;
                        alu_op     <= sel_id ? req1_op : req0_op;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        resp_data  <= alu_result;
                        resp_id    <= grant_id;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_DIVZ_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if ((state == EXEC) && (cnt == 4'd0)) begin
            resp_err <= (alu_op == 3'b111) && (alu_b == 4'd0);
        end
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: behavioural ALU, expected-response queue,
// negedge monitor for handshake/stability rules, directed and random stimulus.
module tb_alu_req_arbiter;

    localparam int EXEC_CYCLES = 3;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [2:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [2:0] req1_op;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       resp_valid, resp_ready, resp_id, resp_err;
    logic [7:0] resp_data;

    int n_checks = 0;
    int n_err    = 0;
    int n_resp   = 0;
    int cyc      = 0;

    logic [9:0]  exp_q[$];
    logic        busy = 1'b0;
    logic        lat_done = 1'b0;
    int          acc_cyc = 0;
    logic [10:0] held_alu = '0;
    logic        model_last = 1'b1;
    logic        prev_rv = 1'b0;
    logic        prev_rr = 1'b0;
    logic [9:0]  prev_resp = '0;
    logic        m_id, m_exp_id;
    logic [3:0]  m_a, m_b;
    logic [2:0]  m_op;
    logic [9:0]  m_e;

    alu_req_arbiter #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        case (op)
            3'b000:  return {4'd0, a} + {4'd0, b};
            3'b001:  return {4'd0, a} - {4'd0, b};
            3'b010:  return {4'd0, a & b};
            3'b011:  return {4'd0, a | b};
            3'b100:  return {4'd0, a ^ b};
            3'b101:  return {3'd0, a, 1'b0};
            3'b110:  return {4'd0, a} * {4'd0, b};
            default: return (b == 4'd0) ? 8'hFF : {4'd0, a / b};
        endcase
    endfunction

    function automatic logic exp_err(input logic [3:0] b, input logic [2:0] op);
`ifdef ALU_ARB_DIVZ_ERR_EN
        return (op == 3'b111) && (b == 4'd0);
`else
        return 1'b0;
`endif
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    // Monitor and scoreboard
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy       = 1'b0;
            model_last = 1'b1;
            prev_rv    = 1'b0;
        end else begin
            check("one_ready", 32'(req0_ready & req1_ready), 0);
            check("ready_wo_valid", 32'((req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)), 0);
            check("resp_spurious", 32'(resp_valid & ~busy), 0);
            if (busy) begin
                check("ready_busy", 32'(req0_ready | req1_ready), 0);
                check("alu_hold", 32'({alu_a, alu_b, alu_op}), 32'(held_alu));
                if (resp_valid && !lat_done) begin
                    check("latency", 32'(cyc - acc_cyc), EXEC_CYCLES + 1);
                    lat_done = 1'b1;
                end
                if (prev_rv && !prev_rr)
                    check("resp_hold", 32'({resp_valid, resp_id, resp_err, resp_data}),
                          32'({1'b1, prev_resp}));
                if (resp_valid && resp_ready) begin
                    check("resp_q_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        m_e = exp_q.pop_front();
                        check("resp", 32'({resp_id, resp_err, resp_data}), 32'(m_e));
                    end
                    busy = 1'b0;
                    n_resp++;
                end
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                m_id     = req1_valid && req1_ready;
                m_exp_id = (req0_valid && req1_valid) ? ~model_last : req1_valid;
                check("grant", 32'(m_id), 32'(m_exp_id));
                model_last = m_id;
                m_a  = m_id ? req1_a  : req0_a;
                m_b  = m_id ? req1_b  : req0_b;
                m_op = m_id ? req1_op : req0_op;
                exp_q.push_back({m_id, exp_err(m_b, m_op), alu_f(m_a, m_b, m_op)});
                held_alu = {m_a, m_b, m_op};
                busy     = 1'b1;
                lat_done = 1'b0;
                acc_cyc  = cyc;
            end
            prev_rv   = resp_valid;
            prev_rr   = resp_ready;
            prev_resp = {resp_id, resp_err, resp_data};
        end
    end

    // Driver tasks
    task automatic drive_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                             input logic [2:0] op);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic wait_accept(input logic id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 200);
        check("accept_timeout", 32'(n < 200), 1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic send(input logic id, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op);
        drive_req(id, a, b, op);
        wait_accept(id);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_timeout", 32'(n < 400), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp"}, 32'({resp_valid, resp_id, resp_err, resp_data}), 0);
        check({tag, "_alu"}, 32'({alu_a, alu_b, alu_op}), 0);
        check({tag, "_ready"}, 32'({req0_ready, req1_ready}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, n;
        logic hs0, hs1;
        rst = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;

        // Single request: 3+5
        send(1'b0, 4'd3, 4'd5, 3'b000);
        wait_drain();

        // Both continuously valid: alternating grants
        drive_req(1'b0, 4'd2, 4'd7, 3'b110);
        drive_req(1'b1, 4'd9, 4'd4, 3'b001);
        t = n_resp + 4;
        n = 0;
        while (n_resp < t && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("fair_timeout", 32'(n_resp >= t), 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();

        // Backpressure for 5 cycles with req1 waiting
        resp_ready = 1'b0;
        send(1'b0, 4'd15, 4'd15, 3'b110);
        drive_req(1'b1, 4'd1, 4'd2, 3'b000);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("bp_valid", 32'(resp_valid), 1);
        check("bp_data", 32'(resp_data), 32'h0E1);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_accept(1'b1);
        wait_drain();

        // Divide by zero
        send(1'b1, 4'd9, 4'd0, 3'b111);
        wait_drain();

        // Reset during EXEC, then a tie must go to requester 0
        send(1'b0, 4'd1, 4'd1, 3'b000);
        drive_req(1'b0, 4'd6, 4'd3, 3'b001);
        drive_req(1'b1, 4'd5, 4'd5, 3'b010);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        check("tie_after_rst", 32'({req0_ready, req1_ready}), 32'(2'b10));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_accept(1'b1);
        wait_drain();

        // Random traffic with random backpressure and withdrawn requests
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (hs0 || (req0_valid && $urandom_range(0, 7) == 0)) req0_valid = 1'b0;
            if (hs1 || (req1_valid && $urandom_range(0, 7) == 0)) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 2) == 0)
                drive_req(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)));
            if (!req1_valid && $urandom_range(0, 2) == 0)
                drive_req(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)));
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
